add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arb_pkg.sv | 26 ++
 rtl/add_arbiter_if.sv | 35 +++
 rtl/add.sv | 32 +++
 rtl/add_arbiter.sv | 119 +++++++++++
 tb/tb_add_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and constants for the round-robin saturating-add arbiter.
package add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESULT
    } state_e;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int ID_WIDTH        = $clog2(NUM_REQ_DEFAULT);

    // Two's-complement clip limits for the supported operand widths
    localparam logic [7:0]  SAT_MAX_8  = 8'h7F;
    localparam logic [7:0]  SAT_MIN_8  = 8'h80;
    localparam logic [15:0] SAT_MAX_16 = 16'h7FFF;
    localparam logic [15:0] SAT_MIN_16 = 16'h8000;
    localparam logic [31:0] SAT_MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN_32 = 32'h8000_0000;

    // Requester-index width; a single requester still gets a 1-bit id
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Requester and result handshake bundle for add_arbiter.
interface add_arbiter_if
    import add_arb_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = NUM_REQ_DEFAULT
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [NUM_REQ-1:0][WIDTH-1:0] arg1_in;
    logic [NUM_REQ-1:0][WIDTH-1:0] arg2_in;
    logic                          res_valid_out;
    logic                          res_ready_in;
    logic [WIDTH-1:0]              res_sum_out;
    logic                          res_ovrflw_out;
    logic [ID_W-1:0]               res_id_out;
    logic [15:0]                   ovrflw_count_out;

    // Arbiter side
    modport slave (
        input  req_valid_in, arg1_in, arg2_in, res_ready_in,
        output req_ready_out, res_valid_out, res_sum_out, res_ovrflw_out, res_id_out,
               ovrflw_count_out
    );

    // Requester / consumer side
    modport master (
        output req_valid_in, arg1_in, arg2_in, res_ready_in,
        input  req_ready_out, res_valid_out, res_sum_out, res_ovrflw_out, res_id_out,
               ovrflw_count_out
    );

endinterface

// File: rtl/add.sv
// Combinational signed fixed-point adder with saturation to the format limits.
module add #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovrflw
);
    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Both operands share the Q format, so the binary point needs no alignment
    if (FRAC_WIDTH < 0 || FRAC_WIDTH >= WIDTH) begin : g_bad_format
        $error("add: FRAC_WIDTH must lie in [0, WIDTH-1]");
    end

    logic signed [WIDTH:0] full;

    // One guard bit exposes overflow as a mismatch of the top two bits
    always_comb begin
        full   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        ovrflw = full[WIDTH] ^ full[WIDTH-1];
        if (ovrflw) begin
            sum = full[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            sum = full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding a shared saturating adder: IDLE grants, CALC adds,
// RESULT holds the registered sum until the consumer takes it.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int NUM_REQ    = NUM_REQ_DEFAULT
) (
    input logic          clk_in,
    input logic          rst_in,
    add_arbiter_if.slave bus
);
    localparam int ID_W = id_width(NUM_REQ);

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_next, win_idx, cand, op_id_q, res_id_q;
    logic                    win_found, grant;
    logic signed [WIDTH-1:0] op1_q, op2_q, add_sum, res_sum_q;
    logic                    add_ovf, res_ovf_q;
    logic [15:0]             ovf_cnt_q;

    // Round-robin search upward from rr_ptr with wrap-around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.req_valid_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Reset gates the grant so no requester sees a ready while rst_in is high
    assign grant   = (state_q == IDLE) && win_found && !rst_in;
    assign rr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);

    // One-hot ready to the winner, only while idle
    always_comb begin
        bus.req_ready_out = '0;
        if (grant) begin
            bus.req_ready_out[win_idx] = 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = CALC;
            CALC:    state_d = RESULT;
            RESULT:  if (bus.res_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and round-robin pointer; pointer moves only on a grant
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

    // Capture the winner's operands at the accept edge
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            op1_q   <= '0;
            op2_q   <= '0;
            op_id_q <= '0;
        end else if (grant) begin
            op1_q   <= bus.arg1_in[win_idx];
            op2_q   <= bus.arg2_in[win_idx];
            op_id_q <= win_idx;
        end
    end

    add #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_add (
        .a      (op1_q),
        .b      (op2_q),
        .sum    (add_sum),
        .ovrflw (add_ovf)
    );

    // Register the result leaving CALC; overflow counter sticks at all-ones
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            res_sum_q <= '0;
            res_ovf_q <= 1'b0;
            res_id_q  <= '0;
            ovf_cnt_q <= '0;
        end else if (state_q == CALC) begin
            res_sum_q <= add_sum;
            res_ovf_q <= add_ovf;
            res_id_q  <= op_id_q;
            if (add_ovf && ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end
    end

    assign bus.res_valid_out    = (state_q == RESULT);
    assign bus.res_sum_out      = res_sum_q;
    assign bus.res_ovrflw_out   = res_ovf_q;
    assign bus.res_id_out       = res_id_q;
    assign bus.ovrflw_count_out = ovf_cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: driver predicts each grant and result from a
// transaction-level model, monitor pops and compares when a result is taken.
module tb_add_arbiter;
    import add_arb_pkg::*;

    localparam int WIDTH      = 16;
    localparam int FRAC_WIDTH = 8;
    localparam int NUM_REQ    = 4;
    localparam int TIMEOUT    = 64;

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        ovf;
        int          cnt;
    } exp_t;

    logic               clk        = 1'b0;
    logic               rst        = 1'b1;
    int                 n_checks   = 0;
    int                 n_fail     = 0;
    int                 cyc        = 0;
    int                 accept_cyc = -100;
    int                 rdy_force  = 0;
    int                 rr_model   = 0;
    int                 cnt_model  = 0;
    logic [NUM_REQ-1:0] pend       = '0;
    logic [15:0]        a1 [NUM_REQ];
    logic [15:0]        a2 [NUM_REQ];
    exp_t               exp_q [$];

    add_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    add_arbiter #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .NUM_REQ    (NUM_REQ)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not reached (t=%0t)", name, $time);
    endtask

    // Push the requester table onto the bus and let combinational paths settle
    task automatic apply();
        bus.req_valid_in = pend;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.arg1_in[i] = a1[i];
            bus.arg2_in[i] = a2[i];
        end
        #1;
    endtask

    function automatic int model_winner();
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx = (rr_model + i) % NUM_REQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    // Plain integer add, clipped to the signed 16-bit range
    function automatic exp_t model_add(input int id);
        exp_t               e;
        int                 s;
        logic signed [15:0] x, y;
        x     = a1[id];
        y     = a2[id];
        s     = int'(x) + int'(y);
        e.id  = id;
        e.ovf = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        e.sum = 16'(s);
        if (e.ovf && cnt_model < 65535) cnt_model++;
        e.cnt = cnt_model;
        return e;
    endfunction

    function automatic logic [15:0] rand_op();
        int unsigned r = $urandom % 4;
        if (r == 0) return 16'h7F00 + 16'($urandom % 256);
        if (r == 1) return 16'h8000 + 16'($urandom % 256);
        return 16'($urandom);
    endfunction

    // Called at a negedge; waits for the grant, predicts it, returns after accept
    task automatic grant_one(input bit keep, output int got);
        int   w;
        int   n;
        exp_t e;
        got = -1;
        n   = 0;
        while (bus.req_ready_out == '0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready_out == '0) begin
            fail_now("grant_wait");
            return;
        end
        w = model_winner();
        if (w < 0) begin
            fail_now("grant_without_request");
            return;
        end
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready_out[i]) got = i;
        check("grant_vector", 32'(bus.req_ready_out), 32'(1) << w);
        e = model_add(w);
        exp_q.push_back(e);
        accept_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        rr_model = (w + 1) % NUM_REQ;
        pend[w]  = 1'b0;
        if (keep) begin
            pend[w] = 1'b1;
            a1[w]   = 16'($urandom % 256);
            a2[w]   = 16'($urandom % 256);
        end
        apply();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.res_valid_out) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) fail_now("wait_idle");
    endtask

    // Monitor: drives res_ready_in, compares results and hold behaviour
    initial begin : monitor
        exp_t        e;
        bit          hold;
        bit          prev_valid;
        bit          after_hs;
        logic [15:0] h_sum;
        logic        h_ovf;
        logic [1:0]  h_id;
        hold = 0; prev_valid = 0; after_hs = 0;
        h_sum = '0; h_ovf = 1'b0; h_id = '0;
        bus.res_ready_in = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0; prev_valid = 0; after_hs = 0;
                bus.res_ready_in = 1'b0;
                continue;
            end
            if (after_hs && pend != '0) check("regrant_next_cycle", 32'(bus.req_ready_out != '0), 1);
            after_hs = 0;
            if (bus.res_valid_out) begin
                check("ready_zero_in_result", 32'(bus.req_ready_out), 0);
                if (!prev_valid) check("latency", cyc - accept_cyc, 2);
                if (hold) begin
                    check("hold_sum", 32'(bus.res_sum_out), 32'(h_sum));
                    check("hold_ovf", 32'(bus.res_ovrflw_out), 32'(h_ovf));
                    check("hold_id", 32'(bus.res_id_out), 32'(h_id));
                end
            end
            if (rdy_force >= 0) bus.res_ready_in = rdy_force[0];
            else bus.res_ready_in = 1'($urandom % 2);
            hold = 0;
            if (bus.res_valid_out) begin
                if (bus.res_ready_in) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check("res_sum", 32'(bus.res_sum_out), 32'(e.sum));
                        check("res_ovf", 32'(bus.res_ovrflw_out), 32'(e.ovf));
                        check("res_id", 32'(bus.res_id_out), e.id);
                        check("ovf_count", 32'(bus.ovrflw_count_out), e.cnt);
                    end
                    after_hs = 1;
                end else begin
                    hold  = 1;
                    h_sum = bus.res_sum_out;
                    h_ovf = bus.res_ovrflw_out;
                    h_id  = bus.res_id_out;
                end
            end
            prev_valid = bus.res_valid_out;
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int got;
        int n;
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NUM_REQ; i++) begin
            a1[i] = '0;
            a2[i] = '0;
        end
        // Reset with every requester asking: nothing may be granted
        pend = '1;
        apply();
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready_out), 0);
        check("rst_res_valid", 32'(bus.res_valid_out), 0);
        check("rst_res_sum", 32'(bus.res_sum_out), 0);
        check("rst_res_ovf", 32'(bus.res_ovrflw_out), 0);
        check("rst_res_id", 32'(bus.res_id_out), 0);
        check("rst_ovf_count", 32'(bus.ovrflw_count_out), 0);
        pend = '0;
        apply();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        rdy_force = -1;

        // Basic add on requester 0
        a1[0] = 16'h0100; a2[0] = 16'h0200; pend[0] = 1'b1;
        apply();
        grant_one(0, got);
        check("basic_id", got, 0);
        wait_idle();

        // Positive saturation on requester 3
        a1[3] = 16'h7F00; a2[3] = 16'h0200; pend[3] = 1'b1;
        apply();
        grant_one(0, got);
        check("pos_sat_id", got, 3);
        wait_idle();
        check("pos_sat_count", 32'(bus.ovrflw_count_out), 1);

        // Fairness with all four held valid
        for (int i = 0; i < NUM_REQ; i++) begin
            a1[i] = 16'(i * 16);
            a2[i] = 16'h0001;
        end
        pend = '1;
        apply();
        for (int k = 0; k < 5; k++) begin
            grant_one(k < 4, got);
            check($sformatf("fair_order_%0d", k), got, order[k]);
        end
        pend = '0;
        apply();
        wait_idle();

        // Negative saturation on requester 1
        a1[1] = 16'h8000; a2[1] = 16'hFF00; pend[1] = 1'b1;
        apply();
        grant_one(0, got);
        check("neg_sat_id", got, 1);
        wait_idle();
        check("neg_sat_count", 32'(bus.ovrflw_count_out), 2);

        // Backpressure: result held, then handshake and an immediate new grant
        rdy_force = 0;
        a1[2] = 16'h1234; a2[2] = 16'h0111; pend[2] = 1'b1;
        apply();
        grant_one(0, got);
        n = 0;
        while (!bus.res_valid_out && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid_out) fail_now("bp_result_wait");
        repeat (5) @(negedge clk);
        check("bp_valid_held", 32'(bus.res_valid_out), 1);
        check("bp_ready_zero", 32'(bus.req_ready_out), 0);
        a1[3] = 16'h0001; a2[3] = 16'h0002; pend[3] = 1'b1;
        apply();
        rdy_force = 1;
        grant_one(0, got);
        check("bp_next_id", got, 3);
        rdy_force = -1;
        wait_idle();

        // Reset during CALC discards the operation
        a1[3] = 16'h0400; a2[3] = 16'h0100; pend[3] = 1'b1;
        apply();
        grant_one(0, got);
        check("rst_mid_pre_id", got, 3);
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        rr_model  = 0;
        cnt_model = 0;
        check("rst_mid_valid", 32'(bus.res_valid_out), 0);
        check("rst_mid_count", 32'(bus.ovrflw_count_out), 0);
        check("rst_mid_sum", 32'(bus.res_sum_out), 0);
        a1[0] = 16'h0005; a2[0] = 16'h0006; pend[0] = 1'b1; pend[3] = 1'b1;
        apply();
        check("rst_mid_ready", 32'(bus.req_ready_out), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_result", 32'(bus.res_valid_out), 0);
        grant_one(0, got);
        check("rst_mid_next_grant", got, 0);
        grant_one(0, got);
        check("rst_mid_then_3", got, 3);
        wait_idle();

        // Randomized traffic with random consumer backpressure
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom % 2) == 1) begin
                    pend[i] = 1'b1;
                    a1[i]   = rand_op();
                    a2[i]   = rand_op();
                end
            end
            if (pend == '0) begin
                n       = int'($urandom % NUM_REQ);
                pend[n] = 1'b1;
                a1[n]   = rand_op();
                a2[n]   = rand_op();
            end
            apply();
            grant_one(0, got);
        end
        pend = '0;
        apply();
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
